sdram_line_port: RTL and testbench



---
 rtl/sdram_line_port_pkg.sv | 30 +++
 rtl/sdram_line_port_if.sv | 41 ++++
 rtl/sdram_line_port_line_buffer.sv | 33 +++
 rtl/sdram_line_port.sv | 132 +++++++++++++
 tb/tb_sdram_line_port.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_line_port_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | line_port_pkg: shared states and constants for sdram_line_port   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package line_port_pkg;

  localparam int          BURST_LEN = 8;
  localparam logic [31:0] HI_OFS    = 32'd0;
  localparam logic [31:0] LO_OFS    = 32'd2;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_CMD     = 3'd1,
    RD_COLLECT = 3'd2,
    RD_STREAM  = 3'd3,
    WR_HI      = 3'd4,
    WR_LO      = 3'd5,
    WR_DONE    = 3'd6
  } state_t;

  // First write state for a given byte-enable set; empty halves issue no command.
  function automatic state_t first_wr_state(input logic [3:0] be);
    if (be[3:2] != 2'b00)      return WR_HI;
    else if (be[1:0] != 2'b00) return WR_LO;
    else                       return WR_DONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_line_port_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sdram_line_port_if: cache-side and controller-side signal bundle |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface sdram_line_port_if;
  logic        fill_req;
  logic [31:0] fill_addr;
  logic        fill;
  logic [15:0] fill_data;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_bytesel;
  logic        wr_ack;
  logic        ctl_req;
  logic        ctl_ack;
  logic        ctl_wr;
  logic        ctl_burst;
  logic [31:0] ctl_addr;
  logic [15:0] ctl_wdata;
  logic [1:0]  ctl_be;
  logic        ctl_rvalid;
  logic [15:0] ctl_rdata;
  logic        err;

  modport slave (
    input  fill_req, fill_addr, wr_req, wr_addr, wr_data, wr_bytesel,
           ctl_ack, ctl_rvalid, ctl_rdata,
    output fill, fill_data, wr_ack, ctl_req, ctl_wr, ctl_burst,
           ctl_addr, ctl_wdata, ctl_be, err
  );

  modport master (
    output fill_req, fill_addr, wr_req, wr_addr, wr_data, wr_bytesel,
           ctl_ack, ctl_rvalid, ctl_rdata,
    input  fill, fill_data, wr_ack, ctl_req, ctl_wr, ctl_burst,
           ctl_addr, ctl_wdata, ctl_be, err
  );
endinterface
`default_nettype wire

// File: rtl/sdram_line_port_line_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | line_buffer: 8x16 register file, one write and one read port    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module line_buffer
  import line_port_pkg::*;
(
  input  logic        clk,
  input  logic        we,
  input  logic [2:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [2:0]  raddr,
  output logic [15:0] rdata
);

  logic [15:0] mem_q [BURST_LEN];
  logic [15:0] mem_d [BURST_LEN];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // Contents are don't-care after reset, so no reset term.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/sdram_line_port.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sdram_line_port: cache line fill / CPU write adapter to SDRAM ctl |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module sdram_line_port
  import line_port_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  sdram_line_port_if.slave    bus
);

  localparam logic [2:0] LAST_IDX = 3'(BURST_LEN - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        err_q, err_d;
  logic        buf_we;
  logic [15:0] buf_rdata;
  logic        unused_addr_lsbs;

  assign unused_addr_lsbs = ^{bus.fill_addr[1:0], bus.wr_addr[1:0]};

  // cnt is both the collect write index and the stream read index.
  line_buffer u_line_buffer (
    .clk   (clk),
    .we    (buf_we),
    .waddr (cnt_q),
    .wdata (bus.ctl_rdata),
    .raddr (cnt_q),
    .rdata (buf_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    buf_we  = 1'b0;
    err_d   = bus.ctl_rvalid && (state_q != RD_COLLECT);
    case (state_q)
      IDLE: begin
        if (bus.wr_req) begin
          addr_d  = {bus.wr_addr[31:2], 2'b00};
          wdata_d = bus.wr_data;
          be_d    = bus.wr_bytesel;
          state_d = first_wr_state(bus.wr_bytesel);
        end else if (bus.fill_req) begin
          addr_d  = {bus.fill_addr[31:2], 2'b00};
          state_d = RD_CMD;
        end
      end
      RD_CMD: if (bus.ctl_ack) state_d = RD_COLLECT;
      RD_COLLECT: begin
        if (bus.ctl_rvalid) begin
          buf_we = 1'b1;
          cnt_d  = cnt_q + 3'd1;
          if (cnt_q == LAST_IDX) state_d = RD_STREAM;
        end
      end
      RD_STREAM: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAST_IDX) state_d = IDLE;
      end
      WR_HI: if (bus.ctl_ack) state_d = (be_q[1:0] != 2'b00) ? WR_LO : WR_DONE;
      WR_LO: if (bus.ctl_ack) state_d = WR_DONE;
      WR_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ctl_req   = 1'b0;
    bus.ctl_wr    = 1'b0;
    bus.ctl_burst = 1'b0;
    bus.ctl_addr  = 32'd0;
    bus.ctl_wdata = 16'd0;
    bus.ctl_be    = 2'b00;
    case (state_q)
      RD_CMD: begin
        bus.ctl_req   = 1'b1;
        bus.ctl_burst = 1'b1;
        bus.ctl_addr  = addr_q;
      end
      WR_HI: begin
        bus.ctl_req   = 1'b1;
        bus.ctl_wr    = 1'b1;
        bus.ctl_addr  = addr_q + HI_OFS;
        bus.ctl_wdata = wdata_q[31:16];
        bus.ctl_be    = be_q[3:2];
      end
      WR_LO: begin
        bus.ctl_req   = 1'b1;
        bus.ctl_wr    = 1'b1;
        bus.ctl_addr  = addr_q + LO_OFS;
        bus.ctl_wdata = wdata_q[15:0];
        bus.ctl_be    = be_q[1:0];
      end
      default: ;
    endcase
  end

  assign bus.fill      = (state_q == RD_STREAM) && (cnt_q == 3'd0);
  assign bus.fill_data = (state_q == RD_STREAM) ? buf_rdata : 16'd0;
  assign bus.wr_ack    = (state_q == WR_DONE);
  assign bus.err       = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      err_q   <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdram_line_port.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_sdram_line_port: directed self-checking bench for the adapter |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_sdram_line_port;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  sdram_line_port_if bus ();

  sdram_line_port dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_req"},   32'(bus.ctl_req),   32'd0);
    chk({tag, "_fill"},  32'(bus.fill),      32'd0);
    chk({tag, "_fdata"}, 32'(bus.fill_data), 32'd0);
    chk({tag, "_wrack"}, 32'(bus.wr_ack),    32'd0);
    chk({tag, "_err"},   32'(bus.err),       32'd0);
  endtask

  // Full line read: ack after ack_dly cycles, gap idle cycles before each halfword.
  task automatic do_read(input logic [31:0] addr, input int ack_dly, input int gap,
                         input logic [15:0] base);
    int req_cycles;
    int early_fill;
    bus.fill_req  = 1'b1;
    bus.fill_addr = addr;
    tick();
    chk("rd_req",   32'(bus.ctl_req),   32'd1);
    chk("rd_wr",    32'(bus.ctl_wr),    32'd0);
    chk("rd_burst", 32'(bus.ctl_burst), 32'd1);
    chk("rd_addr",  bus.ctl_addr,       {addr[31:2], 2'b00});
    req_cycles = 0;
    for (int i = 0; i <= ack_dly; i++) begin
      if (bus.ctl_req && bus.ctl_addr == {addr[31:2], 2'b00}) req_cycles++;
      bus.ctl_ack = (i == ack_dly);
      tick();
    end
    bus.ctl_ack = 1'b0;
    chk("rd_req_cycles", 32'(req_cycles), 32'(ack_dly + 1));
    chk("rd_req_drop",   32'(bus.ctl_req), 32'd0);
    early_fill = 0;
    for (int k = 0; k < 8; k++) begin
      for (int g = 0; g < gap; g++) begin
        bus.ctl_rvalid = 1'b0;
        tick();
        if (bus.fill) early_fill++;
      end
      bus.ctl_rvalid = 1'b1;
      bus.ctl_rdata  = base + 16'(k);
      tick();
      if (k < 7 && bus.fill) early_fill++;
    end
    bus.ctl_rvalid = 1'b0;
    chk("rd_early_fill", 32'(early_fill), 32'd0);
    chk("rd_fill",       32'(bus.fill),   32'd1);
    chk("rd_fdata0",     32'(bus.fill_data), 32'(base));
    bus.fill_req = 1'b0;
    for (int k = 1; k < 8; k++) begin
      tick();
      chk("rd_fill_lo", 32'(bus.fill),      32'd0);
      chk("rd_fdata",   32'(bus.fill_data), 32'(base + 16'(k)));
    end
    tick();
    chk_quiet("rd_end");
  endtask

  // Single CPU write with immediate controller acks.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] be);
    bus.wr_req     = 1'b1;
    bus.wr_addr    = addr;
    bus.wr_data    = data;
    bus.wr_bytesel = be;
    tick();
    if (be[3:2] != 2'b00) begin
      chk("wr_hi_req",   32'(bus.ctl_req),   32'd1);
      chk("wr_hi_wr",    32'(bus.ctl_wr),    32'd1);
      chk("wr_hi_burst", 32'(bus.ctl_burst), 32'd0);
      chk("wr_hi_addr",  bus.ctl_addr,       {addr[31:2], 2'b00});
      chk("wr_hi_data",  32'(bus.ctl_wdata), 32'(data[31:16]));
      chk("wr_hi_be",    32'(bus.ctl_be),    32'(be[3:2]));
      chk("wr_hi_ack",   32'(bus.wr_ack),    32'd0);
      bus.ctl_ack = 1'b1;
      tick();
      bus.ctl_ack = 1'b0;
    end
    if (be[1:0] != 2'b00) begin
      chk("wr_lo_req",   32'(bus.ctl_req),   32'd1);
      chk("wr_lo_wr",    32'(bus.ctl_wr),    32'd1);
      chk("wr_lo_addr",  bus.ctl_addr,       {addr[31:2], 2'b00} + 32'd2);
      chk("wr_lo_data",  32'(bus.ctl_wdata), 32'(data[15:0]));
      chk("wr_lo_be",    32'(bus.ctl_be),    32'(be[1:0]));
      chk("wr_lo_ack",   32'(bus.wr_ack),    32'd0);
      bus.ctl_ack = 1'b1;
      tick();
      bus.ctl_ack = 1'b0;
    end
    chk("wr_ack",      32'(bus.wr_ack),  32'd1);
    chk("wr_ack_nreq", 32'(bus.ctl_req), 32'd0);
    bus.wr_req = 1'b0;
    tick();
    chk("wr_ack_once", 32'(bus.wr_ack),  32'd0);
  endtask

  initial begin
    int errs;
    int fills;
    n_tests        = 0;
    n_fail         = 0;
    bus.fill_req   = 1'b0;
    bus.fill_addr  = 32'd0;
    bus.wr_req     = 1'b0;
    bus.wr_addr    = 32'd0;
    bus.wr_data    = 32'd0;
    bus.wr_bytesel = 4'd0;
    bus.ctl_ack    = 1'b0;
    bus.ctl_rvalid = 1'b0;
    bus.ctl_rdata  = 16'd0;
    reset          = 1'b1;
    tick();
    tick();
    chk_quiet("reset");
    reset = 1'b0;
    tick();
    chk_quiet("idle");

    do_read(32'h0000_1008, 0, 0, 16'hA000);
    do_read(32'h0000_1008, 5, 3, 16'hB100);

    do_write(32'h0000_2000, 32'hDEAD_BEEF, 4'b1111);
    do_write(32'h0000_2000, 32'hDEAD_BEEF, 4'b0010);
    do_write(32'h0000_2000, 32'hDEAD_BEEF, 4'b0000);
    do_write(32'h0000_2103, 32'h1234_5678, 4'b0100);

    // Write wins over a simultaneous fill; the read follows after wr_ack.
    bus.fill_req  = 1'b1;
    bus.fill_addr = 32'h0000_3010;
    do_write(32'h0000_2008, 32'hCAFE_F00D, 4'b1001);
    do_read(32'h0000_3010, 0, 0, 16'hD300);

    // Reset while a command is pending drops ctl_req at once.
    bus.fill_req  = 1'b1;
    bus.fill_addr = 32'h0000_5000;
    tick();
    chk("rst_cmd_req", 32'(bus.ctl_req), 32'd1);
    bus.fill_req = 1'b0;
    #2 reset = 1'b1;
    #1 chk("rst_cmd_req0",  32'(bus.ctl_req),  32'd0);
    chk("rst_cmd_addr0", bus.ctl_addr, 32'd0);
    #2 reset = 1'b0;
    tick();

    // Reset after the 4th halfword abandons the line.
    bus.fill_req  = 1'b1;
    bus.fill_addr = 32'h0000_6004;
    tick();
    bus.ctl_ack = 1'b1;
    tick();
    bus.ctl_ack  = 1'b0;
    bus.fill_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.ctl_rvalid = 1'b1;
      bus.ctl_rdata  = 16'hE000 + 16'(k);
      tick();
    end
    bus.ctl_rvalid = 1'b0;
    #2 reset = 1'b1;
    #1 chk_quiet("rst_mid");
    #2 reset = 1'b0;
    tick();
    errs  = 0;
    fills = 0;
    for (int k = 0; k < 4; k++) begin
      bus.ctl_rvalid = 1'b1;
      bus.ctl_rdata  = 16'hE004 + 16'(k);
      tick();
      if (bus.err) errs++;
      if (bus.fill) fills++;
    end
    bus.ctl_rvalid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.err) errs++;
      if (bus.fill) fills++;
    end
    chk("late_err_cnt",  32'(errs),  32'd4);
    chk("late_fill_cnt", 32'(fills), 32'd0);

    do_read(32'h0000_400E, 2, 1, 16'hC200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
